// File: rtl/stackcalc_host_driver.sv
// stackcalc_host_driver: buffers a nibble program and streams it to the stack calculator pins.
//   clk, rst                  system clock, synchronous active-high reset
//   load_valid/nibble/ready   program buffer write port (IDLE only)
//   clear                     empty the buffer (IDLE only, beats a same-cycle load)
//   start, busy, done         run control; done pulses on the last cpu_clk period
//   prog_len                  number of stored nibbles
//   cpu_clk, cpu_rst, cpu_nibble  calculator io_in[0], io_in[1], io_in[5:2]
//   cpu_out                   calculator io_out
//   result, result_valid      cpu_out captured at run end, pulse coincident with done
module stackcalc_host_driver #(
  parameter int DEPTH = 16,
  parameter int HALF_PERIOD = 2,
  parameter int RST_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [3:0]                 load_nibble,
  output logic                       load_ready,
  input  logic                       clear,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     prog_len,
  output logic                       cpu_clk,
  output logic                       cpu_rst,
  output logic [3:0]                 cpu_nibble,
  input  logic [7:0]                 cpu_out,
  output logic [7:0]                 result,
  output logic                       result_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam int RW = $clog2(RST_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RESET_CPU, STREAM} state_t;
  state_t state;
  logic [3:0] mem [DEPTH];
  logic [PW-1:0] ph, ph_nx;
  logic [RW-1:0] rcnt;
  logic [LW-1:0] idx, idx_nx;
  logic load_acc, start_ok, ph_end, last;
  assign load_ready = state == IDLE && prog_len < LW'(DEPTH);
  assign load_acc = load_valid && load_ready && !clear;
  // A load in the same cycle as start counts towards the non-empty check.
  assign start_ok = state == IDLE && start && !clear && (prog_len != '0 || load_acc);
  assign ph_end = ph == PW'(2 * HALF_PERIOD - 1);
  assign ph_nx = ph_end ? '0 : ph + PW'(1);
  assign last = idx == prog_len - LW'(1);
  assign idx_nx = idx + LW'(1);
  always_ff @(posedge clk)
    if (load_acc) mem[prog_len[AW-1:0]] <= load_nibble;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prog_len <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
      cpu_clk <= 1'b0;
      cpu_rst <= 1'b0;
      cpu_nibble <= '0;
      ph <= '0;
      rcnt <= '0;
      idx <= '0;
    end else begin
      done <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) prog_len <= '0;
          else if (load_acc) prog_len <= prog_len + LW'(1);
          if (start_ok) begin
            state <= RESET_CPU;
            busy <= 1'b1;
            ph <= '0;
            rcnt <= '0;
            cpu_rst <= 1'b1;
            cpu_nibble <= '0;
            cpu_clk <= 1'b0;
          end
        end
        RESET_CPU: begin
          ph <= ph_nx;
          cpu_clk <= ph_nx >= PW'(HALF_PERIOD);
          if (ph_end) begin
            if (rcnt == RW'(RST_CYCLES - 1)) begin
              state <= STREAM;
              idx <= '0;
              cpu_rst <= 1'b0;
              cpu_nibble <= mem[AW'(0)];
            end else rcnt <= rcnt + RW'(1);
          end
        end
        STREAM: begin
          ph <= ph_nx;
          cpu_clk <= ph_nx >= PW'(HALF_PERIOD);
          // Registered one edge early so done/result appear during the final phase cycle.
          if (ph == PW'(2 * HALF_PERIOD - 2) && last) begin
            done <= 1'b1;
            result_valid <= 1'b1;
            result <= cpu_out;
          end
          if (ph_end) begin
            if (last) begin
              state <= IDLE;
              busy <= 1'b0;
              cpu_nibble <= '0;
            end else begin
              idx <= idx_nx;
              cpu_nibble <= mem[idx_nx[AW-1:0]];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stackcalc_host_driver.sv
// tb_stackcalc_host_driver: directed scoreboard bench for stackcalc_host_driver.
module tb_stackcalc_host_driver;
  localparam int HP = 2;
  localparam int RC = 2;
  logic clk = 1'b0;
  logic rst, load_valid, clear, start, load_ready, busy, done, cpu_clk, cpu_rst, result_valid;
  logic [3:0] load_nibble, cpu_nibble;
  logic [4:0] prog_len;
  logic [7:0] cpu_out, result;
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] prog [$];
  logic [7:0] sb [$];
  always #5 clk = ~clk;
  stackcalc_host_driver #(.DEPTH(16), .HALF_PERIOD(HP), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_nibble(load_nibble),
    .load_ready(load_ready), .clear(clear), .start(start), .busy(busy), .done(done),
    .prog_len(prog_len), .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .cpu_nibble(cpu_nibble),
    .cpu_out(cpu_out), .result(result), .result_valid(result_valid)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(logic [3:0] n);
    load_valid = 1'b1;
    load_nibble = n;
    step();
    load_valid = 1'b0;
  endtask
  // Starts a run on the current buffer and checks every cycle of the pin waveform.
  task automatic run(logic [7:0] co, int poke_k, bit fuse_load, logic [3:0] fl);
    int lat, p, ph;
    logic [8:0] e;
    cpu_out = co;
    if (fuse_load) begin
      load_valid = 1'b1;
      load_nibble = fl;
      prog.push_back(fl);
    end
    start = 1'b1;
    sb.push_back(co);
    step();
    start = 1'b0;
    load_valid = 1'b0;
    lat = (RC + prog.size()) * 2 * HP;
    for (int k = 1; k <= lat + 1; k++) begin
      p = (k - 1) / (2 * HP);
      ph = (k - 1) % (2 * HP);
      if (k > lat) e = '0;
      else if (p < RC) e = {1'b1, k == lat, k == lat, 1'b1, ph >= HP, 4'h0};
      else e = {1'b1, k == lat, k == lat, 1'b0, ph >= HP, prog[p - RC]};
      chk("wave", {busy, done, result_valid, cpu_rst, cpu_clk, cpu_nibble}, e);
      if (done) begin
        chk("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) chk("result", result, sb.pop_front());
      end
      if (k == poke_k) begin
        start = 1'b1;
        load_valid = 1'b1;
        clear = 1'b1;
        load_nibble = 4'hF;
      end
      step();
      start = 1'b0;
      load_valid = 1'b0;
      clear = 1'b0;
    end
    chk("sb_drained", sb.size(), 0);
    chk("len_kept", prog_len, prog.size());
  endtask
  initial begin
    int pulses;
    rst = 1'b1;
    load_valid = 1'b0;
    load_nibble = '0;
    clear = 1'b0;
    start = 1'b0;
    cpu_out = '0;
    step();
    step();
    chk("rst_outs", {busy, done, result_valid, cpu_clk, cpu_rst, cpu_nibble}, 0);
    chk("rst_result", result, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_ready", load_ready, 1);
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("empty_start", {busy, done}, 0);
      step();
    end
    for (int i = 1; i <= 3; i++) begin
      load(4'(i));
      prog.push_back(4'(i));
    end
    chk("len3", prog_len, 3);
    run(8'hA5, 0, 1'b0, 4'h0);
    chk("result_hold", result, 8'hA5);
    run(8'h3C, 14, 1'b0, 4'h0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    prog.delete();
    chk("clear", prog_len, 0);
    load(4'h9);
    load(4'h8);
    chk("len2", prog_len, 2);
    clear = 1'b1;
    load(4'h6);
    clear = 1'b0;
    chk("clear_load", prog_len, 0);
    run(8'h5A, 0, 1'b1, 4'h7);
    clear = 1'b1;
    step();
    clear = 1'b0;
    prog.delete();
    for (int i = 0; i < 17; i++) begin
      chk("full_ready", load_ready, i < 16);
      load(4'(i * 7));
      if (i < 16) prog.push_back(4'(i * 7));
    end
    chk("full_len", prog_len, 16);
    chk("full_ready_end", load_ready, 0);
    run(8'hC3, 0, 1'b0, 4'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("abort_pre", {busy, cpu_rst, cpu_clk}, 3'b101);
    rst = 1'b1;
    step();
    rst = 1'b0;
    prog.delete();
    chk("abort_outs", {busy, cpu_clk, cpu_rst, cpu_nibble}, 0);
    chk("abort_len", prog_len, 0);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      pulses += int'(done);
      step();
    end
    chk("abort_nodone", pulses, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
